ibexc_tsmap_arbiter: RTL and testbench
======================================

// Module: ibexc_tsmap_arbiter
// PURPOSE
// Shares the single-port TS-map (revocation bitmap) SRAM between two requesters:
// - Core tsmap read port: cannot stall, fixed 1-cycle read latency.
// - Bus-side port used by the allocator/revoker: read, write, and atomic bit set/clear.
// The core always wins. Bus accesses fill idle cycles; SET/CLR run as an internal read-modify-write (RMW).
// Sits between ibexc_top (tsmap_cs_o/tsmap_addr_o/tsmap_rdata_i) and the TS-map RAM macro.
// PARAMETERS
// TSMapSize  1024  RAM depth in 32-bit words; bus addresses >= TSMapSize are errors
// AddrW      16    word-address width on all ports
// StallMax   255   consecutive bus-blocked cycles before starve_o asserts (counter saturates here)
// PORTS
// clk_i          in   1      clock
// rst_ni         in   1      async active-low reset
// core_cs_i      in   1      core read request (from tsmap_cs_o)
// core_addr_i    in   AddrW  core word address
// core_rdata_o   out  32     core read data, valid the cycle after core_cs_i
// bus_req_i      in   1      bus request; held with all bus_* inputs stable until bus_gnt_o
// bus_op_i       in   2      tsmap_op_e: READ=0, WRITE=1, SET=2, CLR=3
// bus_addr_i     in   AddrW  bus word address
// bus_wdata_i    in   32     WRITE: data; SET/CLR: bit mask
// bus_be_i       in   4      WRITE byte enables; ignored for other ops
// bus_gnt_o      out  1      request accepted this cycle
// bus_rvalid_o   out  1      response valid, single cycle
// bus_rdata_o    out  32     READ: word; SET/CLR: pre-modify word; WRITE/err: 0
// bus_err_o      out  1      qualifies bus_rvalid_o: out-of-range address
// ram_req_o      out  1      RAM access strobe
// ram_we_o       out  1      RAM write enable
// ram_addr_o     out  AddrW  RAM word address
// ram_wdata_o    out  32     RAM write data
// ram_be_o       out  4      RAM byte enables
// ram_rdata_i    in   32     RAM read data, 1 cycle after a read strobe
// starve_o       out  1      bus blocked for >= StallMax consecutive cycles
// BEHAVIOUR
// Reset values: all outputs 0; state IDLE; stall counter 0.
// Port mux, one RAM access per cycle:
// - core_cs_i=1: ram_req=1, we=0, addr=core_addr_i, every cycle, regardless of state.
// - core_rdata_o = ram_rdata_i (combinational passthrough). Content is meaningful only the cycle after core_cs_i.
// States: IDLE, RMW_CAP, RMW_WR.
// IDLE:
// - bus_gnt_o = bus_req_i & ~core_cs_i.
// - Out-of-range address: granted with no RAM access; next cycle rvalid=1, err=1.
// - READ: ram read; next cycle rvalid=1, bus_rdata_o=ram_rdata_i.
// - WRITE: ram write with bus_be_i; next cycle rvalid=1.
// - READ/WRITE stay in IDLE, so back-to-back grants are allowed.
// - SET/CLR: ram read; latch addr and mask; go to RMW_CAP.
// RMW_CAP:
// - Capture ram_rdata_i into old_q; go to RMW_WR.
// - Unconditional; a core request this cycle is still serviced.
// - bus_gnt_o=0.
// RMW_WR:
// - If ~core_cs_i: write old_q|mask (SET) or old_q&~mask (CLR) with be=4'hF; go to IDLE.
// - Next cycle: rvalid=1, bus_rdata_o=old_q.
// - Else hold. Holding is safe because this block is the RAM's only writer. bus_gnt_o=0.
// Response latency is 1 cycle after grant for READ/WRITE/err, and 3+N cycles after grant for SET/CLR (N = cycles stalled in RMW_WR).
// Core reads to the RMW address during RMW_CAP/RMW_WR return the pre-modify value. This is intended.
// Stall counter:
// - Increments when (bus_req_i in IDLE, or RMW_WR) and core_cs_i=1.
// - Clears on any cycle the bus or RMW accesses the RAM.
// - Saturates at StallMax; starve_o = (cnt == StallMax).
// Response generation: a registered pending flag plus rdata-owner bit. rvalid is never asserted twice for one grant.
// Reset mid-RMW: the RMW is discarded and the RAM is left unmodified if RMW_WR had not written. No response is issued.
// bus_req_i dropped before grant: no effect (protocol violation; assertion only).
// STRUCTURE
// - cheri_pkg gains: typedef enum logic [1:0] tsmap_op_e {TSMAP_READ, TSMAP_WRITE, TSMAP_SET, TSMAP_CLR}.
// - FSM state enum stays local.
// - Single flat module, no sub-modules.
// - SVA: no ram access without core_cs_i or grant/RMW_WR; one rvalid per grant; gnt implies ~core_cs_i.
// TESTING
// 1 Core reads addr 5 every cycle while bus READ addr 6 is pending -> no gnt, starve_o at cycle StallMax.
//   Drop core_cs -> gnt, then rvalid with mem[6].
// 2 mem[3]=32'h0000_00F0; bus SET 3 mask 32'h0000_000F -> rvalid rdata=32'h0000_00F0 at grant+3; mem[3]=32'h0000_00FF.
// 3 As 2, but CLR mask 32'h0000_0010 with core_cs_i high for 4 cycles entering RMW_WR.
//   -> write delayed 4 cycles; core read of addr 3 in the window sees 32'h0000_00F0; final mem[3]=32'h0000_00E0.
// 4 Bus WRITE addr 1024 (TSMapSize=1024) -> gnt, no ram_req, next cycle rvalid=1 err=1.
// 5 Back-to-back bus WRITE be=4'b0011 data 32'hAAAA_5555 then READ same addr -> grants on consecutive cycles; READ returns old upper half | 16'h5555.
// 6 Assert rst_ni low in RMW_WR of a SET -> outputs 0, no RAM write, no rvalid; first post-reset READ returns the unmodified word.

Source files
------------

// File: rtl/ibexc_tsmap_arbiter_pkg.sv
// Shared types for the TS-map arbiter: bus op encoding, RMW context and response source.
package ibexc_tsmap_arbiter_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned BeW   = DataW / 8;

    typedef enum logic [1:0] {
        TSMAP_READ  = 2'd0,
        TSMAP_WRITE = 2'd1,
        TSMAP_SET   = 2'd2,
        TSMAP_CLR   = 2'd3
    } tsmap_op_e;

    // Which source drives bus_rdata_o on the response cycle.
    typedef enum logic [1:0] {
        RSRC_NONE = 2'd0,
        RSRC_RAM  = 2'd1,
        RSRC_OLD  = 2'd2
    } rsrc_e;

    typedef struct packed {
        tsmap_op_e        op;
        logic [DataW-1:0] mask;
    } tsmap_rmw_t;

    function automatic logic [DataW-1:0] rmw_apply(input tsmap_op_e        op,
                                                   input logic [DataW-1:0] old,
                                                   input logic [DataW-1:0] mask);
        return (op == TSMAP_CLR) ? (old & ~mask) : (old | mask);
    endfunction

endpackage

// File: rtl/ibexc_tsmap_arbiter.sv
// Shares the single-port TS-map SRAM between the non-stallable core read port and
// the allocator/revoker bus port (read, write, atomic bit set/clear via internal RMW).
module ibexc_tsmap_arbiter
    import ibexc_tsmap_arbiter_pkg::*;
#(
    parameter int unsigned TSMapSize = 1024,
    parameter int unsigned AddrW     = 16,
    parameter int unsigned StallMax  = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             core_cs_i,
    input  logic [AddrW-1:0] core_addr_i,
    output logic [DataW-1:0] core_rdata_o,
    input  logic             bus_req_i,
    input  logic [1:0]       bus_op_i,
    input  logic [AddrW-1:0] bus_addr_i,
    input  logic [DataW-1:0] bus_wdata_i,
    input  logic [BeW-1:0]   bus_be_i,
    output logic             bus_gnt_o,
    output logic             bus_rvalid_o,
    output logic [DataW-1:0] bus_rdata_o,
    output logic             bus_err_o,
    output logic             ram_req_o,
    output logic             ram_we_o,
    output logic [AddrW-1:0] ram_addr_o,
    output logic [DataW-1:0] ram_wdata_o,
    output logic [BeW-1:0]   ram_be_o,
    input  logic [DataW-1:0] ram_rdata_i,
    output logic             starve_o
);

    localparam int unsigned CntW = $clog2(StallMax + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RMW_CAP = 2'd1;
    localparam logic [1:0] ST_RMW_WR  = 2'd2;

    logic [1:0]       state_q, state_d;
    tsmap_rmw_t       rmw_q, rmw_d;
    logic [AddrW-1:0] rmw_addr_q, rmw_addr_d;
    logic [DataW-1:0] old_q, old_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    rsrc_e            src_q, src_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             bus_ram;
    logic             bus_oob;
    tsmap_op_e        bus_op;

    assign bus_op  = tsmap_op_e'(bus_op_i);
    assign bus_oob = (bus_addr_i >= AddrW'(TSMapSize));

    // Core read always owns the RAM; bus and RMW traffic fill the idle cycles.
    always_comb begin
        state_d     = state_q;
        rmw_d       = rmw_q;
        rmw_addr_d  = rmw_addr_q;
        old_d       = old_q;
        pend_d      = 1'b0;
        err_d       = 1'b0;
        src_d       = RSRC_NONE;
        cnt_d       = cnt_q;
        bus_ram     = 1'b0;
        bus_gnt_o   = 1'b0;
        ram_req_o   = core_cs_i;
        ram_we_o    = 1'b0;
        ram_addr_o  = core_addr_i;
        ram_wdata_o = '0;
        ram_be_o    = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus_req_i && !core_cs_i) begin
                    bus_gnt_o = 1'b1;
                    if (bus_oob) begin
                        pend_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        bus_ram    = 1'b1;
                        ram_req_o  = 1'b1;
                        ram_addr_o = bus_addr_i;
                        case (bus_op)
                            TSMAP_READ: begin
                                pend_d = 1'b1;
                                src_d  = RSRC_RAM;
                            end
                            TSMAP_WRITE: begin
                                ram_we_o    = 1'b1;
                                ram_wdata_o = bus_wdata_i;
                                ram_be_o    = bus_be_i;
                                pend_d      = 1'b1;
                            end
                            TSMAP_SET, TSMAP_CLR: begin
                                rmw_d.op   = bus_op;
                                rmw_d.mask = bus_wdata_i;
                                rmw_addr_d = bus_addr_i;
                                state_d    = ST_RMW_CAP;
                            end
                        endcase
                    end
                end
            end
            ST_RMW_CAP: begin
                old_d   = ram_rdata_i;
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                // Holding under core traffic is safe: nothing else writes the RAM.
                if (!core_cs_i) begin
                    bus_ram     = 1'b1;
                    ram_req_o   = 1'b1;
                    ram_we_o    = 1'b1;
                    ram_addr_o  = rmw_addr_q;
                    ram_wdata_o = rmw_apply(rmw_q.op, old_q, rmw_q.mask);
                    ram_be_o    = '1;
                    pend_d      = 1'b1;
                    src_d       = RSRC_OLD;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus_ram) begin
            cnt_d = '0;
        end else if (((state_q == ST_IDLE && bus_req_i) || state_q == ST_RMW_WR) &&
                     core_cs_i && (cnt_q != CntW'(StallMax))) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            rmw_q      <= '0;
            rmw_addr_q <= '0;
            old_q      <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            src_q      <= RSRC_NONE;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rmw_q      <= rmw_d;
            rmw_addr_q <= rmw_addr_d;
            old_q      <= old_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
        end
    end

    assign core_rdata_o = ram_rdata_i;
    assign bus_rvalid_o = pend_q;
    assign bus_err_o    = pend_q & err_q;
    assign starve_o     = (cnt_q == CntW'(StallMax));

    always_comb begin
        bus_rdata_o = '0;
        if (pend_q) begin
            case (src_q)
                RSRC_RAM: bus_rdata_o = ram_rdata_i;
                RSRC_OLD: bus_rdata_o = old_q;
                default:  bus_rdata_o = '0;
            endcase
        end
    end

    a_gnt_no_core: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus_gnt_o |-> !core_cs_i);

    a_ram_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ram_req_o |-> (core_cs_i || bus_gnt_o || state_q == ST_RMW_WR));

    a_one_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus_rvalid_o |-> $past(bus_gnt_o || (state_q == ST_RMW_WR && ram_we_o)));

    a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus_req_i && !bus_gnt_o) |=> (bus_req_i && $stable(bus_op_i) && $stable(bus_addr_i)));

endmodule

// File: tb/tb_ibexc_tsmap_arbiter.sv
// Directed bench for ibexc_tsmap_arbiter with an SRAM model and a response scoreboard.
module tb_ibexc_tsmap_arbiter;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_cs;
    logic [15:0] core_addr;
    logic [31:0] core_rdata;
    logic        bus_req;
    logic [1:0]  bus_op;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        ram_req;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata = '0;
    logic        starve;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_count = 0;

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    logic        bd_en   = 1'b0;
    logic        bd_ram  = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    ibexc_tsmap_arbiter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .core_cs_i    (core_cs),
        .core_addr_i  (core_addr),
        .core_rdata_o (core_rdata),
        .bus_req_i    (bus_req),
        .bus_op_i     (bus_op),
        .bus_addr_i   (bus_addr),
        .bus_wdata_i  (bus_wdata),
        .bus_be_i     (bus_be),
        .bus_gnt_o    (gnt),
        .bus_rvalid_o (rvalid),
        .bus_rdata_o  (rdata),
        .bus_err_o    (err),
        .ram_req_o    (ram_req),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_be_o     (ram_be),
        .ram_rdata_i  (ram_rdata),
        .starve_o     (starve)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] v, input logic to_ram);
        bd_en   = 1'b1;
        bd_ram  = to_ram;
        bd_addr = a;
        bd_data = v;
        tick();
        bd_en   = 1'b0;
    endtask

    task automatic bus_drive(input logic [1:0] op, input logic [15:0] a,
                             input logic [31:0] d, input logic [3:0] be);
        bus_req   = 1'b1;
        bus_op    = op;
        bus_addr  = a;
        bus_wdata = d;
        bus_be    = be;
    endtask

    // SRAM model: one access per cycle, 1-cycle read latency.
    always @(posedge clk) begin
        cyc++;
        if (bd_en && bd_ram) ram[bd_addr] <= bd_data;
        if (ram_req) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) ram[ram_addr[9:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
                wr_count++;
            end else begin
                ram_rdata <= ram[ram_addr[9:0]];
            end
        end
    end

    // Scoreboard: expected responses queued on grant, compared on rvalid.
    always @(negedge clk) begin
        if (bd_en) ref_mem[bd_addr] = bd_data;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (ram_req) chk("ram_addr_range", 32'(ram_addr < 16'(DEPTH)), 32'd1);
            if (rvalid) begin
                if (sb.size() == 0) begin
                    chk("rvalid_unexpected", 32'(rvalid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_rdata", rdata, e.rdata);
                    chk("sb_err", 32'(err), 32'(e.err));
                    if (e.due >= 0) chk("sb_latency", 32'(cyc), 32'(e.due));
                end
            end
            if (gnt) begin
                chk("gnt_vs_core", 32'(core_cs), 32'd0);
                if (bus_addr >= 16'(DEPTH)) begin
                    sb.push_back('{1'b1, 32'h0, cyc + 1});
                end else begin
                    case (bus_op)
                        2'd0: sb.push_back('{1'b0, ref_mem[bus_addr[9:0]], cyc + 1});
                        2'd1: begin
                            sb.push_back('{1'b0, 32'h0, cyc + 1});
                            for (int b = 0; b < 4; b++)
                                if (bus_be[b]) ref_mem[bus_addr[9:0]][8*b +: 8] = bus_wdata[8*b +: 8];
                        end
                        2'd2: begin
                            sb.push_back('{1'b0, ref_mem[bus_addr[9:0]], -1});
                            ref_mem[bus_addr[9:0]] = ref_mem[bus_addr[9:0]] | bus_wdata;
                        end
                        default: begin
                            sb.push_back('{1'b0, ref_mem[bus_addr[9:0]], -1});
                            ref_mem[bus_addr[9:0]] = ref_mem[bus_addr[9:0]] & ~bus_wdata;
                        end
                    endcase
                end
            end
        end
    end

    initial begin
        int g;
        int w;
        rst_n     = 1'b0;
        core_cs   = 1'b0;
        core_addr = '0;
        bus_req   = 1'b0;
        bus_op    = 2'd0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_be    = '0;
        #2;
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_starve", 32'(starve), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ram_req", 32'(ram_req), 32'd0);

        preload(10'd5, 32'h5A5A_0005, 1'b1);
        preload(10'd6, 32'hC0DE_0006, 1'b1);
        preload(10'd9, 32'h1234_ABCD, 1'b1);
        preload(10'd12, 32'h0000_0100, 1'b1);
        rst_n = 1'b1;
        tick();

        // 1: core hogs the RAM, bus READ starves until core lets go
        core_cs   = 1'b1;
        core_addr = 16'd5;
        bus_drive(2'd0, 16'd6, 32'h0, 4'h0);
        #1;
        chk("t1_gnt_blocked", 32'(gnt), 32'd0);
        chk("t1_ram_addr_core", 32'(ram_addr), 32'd5);
        for (int i = 1; i <= 255; i++) begin
            tick();
            chk("t1_gnt_held", 32'(gnt), 32'd0);
            if (i == 1)   chk("t1_core_rdata", core_rdata, 32'h5A5A_0005);
            if (i == 254) chk("t1_starve_early", 32'(starve), 32'd0);
            if (i == 255) chk("t1_starve_at_max", 32'(starve), 32'd1);
        end
        tick(2);
        chk("t1_starve_sat", 32'(starve), 32'd1);
        core_cs = 1'b0;
        #1;
        chk("t1_gnt", 32'(gnt), 32'd1);
        chk("t1_ram_addr_bus", 32'(ram_addr), 32'd6);
        tick();
        bus_req = 1'b0;
        #1;
        chk("t1_rvalid", 32'(rvalid), 32'd1);
        chk("t1_rdata", rdata, 32'hC0DE_0006);
        chk("t1_starve_clear", 32'(starve), 32'd0);

        // 2: SET with no core traffic
        preload(10'd3, 32'h0000_00F0, 1'b1);
        bus_drive(2'd2, 16'd3, 32'h0000_000F, 4'h0);
        #1;
        chk("t2_gnt", 32'(gnt), 32'd1);
        chk("t2_rd_we", 32'(ram_we), 32'd0);
        g = cyc;
        tick();
        bus_req = 1'b0;
        #1;
        chk("t2_cap_no_req", 32'(ram_req), 32'd0);
        chk("t2_cap_no_rvalid", 32'(rvalid), 32'd0);
        tick();
        #1;
        chk("t2_wr_we", 32'(ram_we), 32'd1);
        chk("t2_wr_addr", 32'(ram_addr), 32'd3);
        chk("t2_wr_data", ram_wdata, 32'h0000_00FF);
        chk("t2_wr_be", 32'(ram_be), 32'hF);
        tick();
        chk("t2_rvalid", 32'(rvalid), 32'd1);
        chk("t2_rdata", rdata, 32'h0000_00F0);
        chk("t2_latency", 32'(cyc - g), 32'd3);
        chk("t2_mem", ram[3], 32'h0000_00FF);

        // 3: CLR stalled 4 cycles by core reads of the same word
        preload(10'd3, 32'h0000_00F0, 1'b1);
        bus_drive(2'd3, 16'd3, 32'h0000_0010, 4'h0);
        #1;
        chk("t3_gnt", 32'(gnt), 32'd1);
        g = cyc;
        tick();
        bus_req = 1'b0;
        tick();
        core_cs   = 1'b1;
        core_addr = 16'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_hold_no_we", 32'(ram_we), 32'd0);
            chk("t3_hold_no_rvalid", 32'(rvalid), 32'd0);
            if (k > 0) chk("t3_core_pre_value", core_rdata, 32'h0000_00F0);
            tick();
        end
        core_cs = 1'b0;
        #1;
        chk("t3_core_last", core_rdata, 32'h0000_00F0);
        chk("t3_wr_we", 32'(ram_we), 32'd1);
        chk("t3_wr_data", ram_wdata, 32'h0000_00E0);
        tick();
        chk("t3_rvalid", 32'(rvalid), 32'd1);
        chk("t3_rdata", rdata, 32'h0000_00F0);
        chk("t3_latency", 32'(cyc - g), 32'd7);
        chk("t3_mem", ram[3], 32'h0000_00E0);

        // 4: out-of-range WRITE
        bus_drive(2'd1, 16'd1024, 32'hDEAD_BEEF, 4'hF);
        #1;
        chk("t4_gnt", 32'(gnt), 32'd1);
        chk("t4_no_ram_req", 32'(ram_req), 32'd0);
        tick();
        bus_req = 1'b0;
        #1;
        chk("t4_rvalid", 32'(rvalid), 32'd1);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_rdata", rdata, 32'h0);

        // 5: back-to-back partial WRITE then READ
        bus_drive(2'd1, 16'd9, 32'hAAAA_5555, 4'b0011);
        #1;
        chk("t5_wr_gnt", 32'(gnt), 32'd1);
        chk("t5_wr_be", 32'(ram_be), 32'h3);
        tick();
        bus_drive(2'd0, 16'd9, 32'h0, 4'h0);
        #1;
        chk("t5_rd_gnt", 32'(gnt), 32'd1);
        chk("t5_wr_rvalid", 32'(rvalid), 32'd1);
        chk("t5_wr_rdata", rdata, 32'h0);
        tick();
        bus_req = 1'b0;
        #1;
        chk("t5_rd_rvalid", 32'(rvalid), 32'd1);
        chk("t5_rd_rdata", rdata, 32'h1234_5555);

        // 6: reset while SET waits in RMW_WR
        bus_drive(2'd2, 16'd12, 32'h0000_0001, 4'h0);
        #1;
        chk("t6_gnt", 32'(gnt), 32'd1);
        tick();
        bus_req   = 1'b0;
        core_cs   = 1'b1;
        core_addr = 16'd5;
        tick();
        chk("t6_stall_no_we", 32'(ram_we), 32'd0);
        chk("t6_pending", 32'(sb.size()), 32'd1);
        w = wr_count;
        rst_n   = 1'b0;
        core_cs = 1'b0;
        #1;
        chk("t6_rst_rvalid", 32'(rvalid), 32'd0);
        chk("t6_rst_rdata", rdata, 32'h0);
        chk("t6_rst_err", 32'(err), 32'd0);
        chk("t6_rst_starve", 32'(starve), 32'd0);
        chk("t6_rst_ram_req", 32'(ram_req), 32'd0);
        tick(2);
        chk("t6_no_write", 32'(wr_count), 32'(w));
        chk("t6_mem_intact", ram[12], 32'h0000_0100);
        preload(10'd12, 32'h0000_0100, 1'b0);
        rst_n = 1'b1;
        tick();
        bus_drive(2'd0, 16'd12, 32'h0, 4'h0);
        #1;
        chk("t6_rd_gnt", 32'(gnt), 32'd1);
        tick();
        bus_req = 1'b0;
        #1;
        chk("t6_rd_rvalid", 32'(rvalid), 32'd1);
        chk("t6_rd_rdata", rdata, 32'h0000_0100);

        tick(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
